// File: rtl/usart_8251_ctrl.sv
// usart_8251_ctrl: 8251-style mode/sync/command write sequencer with status byte and TxRDY
module usart_8251_ctrl #(
    parameter int         WE_SYNC_STAGES = 2,
    parameter bit         SYNC_SUPPORT   = 1'b1,
    parameter logic [7:0] MODE_RESET     = 8'h00
) (
    input  logic       I_CLK,
    input  logic       I_RST,
    input  logic       I_PORT21_WE,
    input  logic [7:0] I_DATA,
    input  logic       I_TX_BUF_EMPTY,
    input  logic       I_TX_EMPTY,
    input  logic       I_RX_RDY,
    input  logic       I_PE_SET,
    input  logic       I_OE_SET,
    input  logic       I_FE_SET,
    input  logic       I_SYNDET,
    input  logic       I_DSR_N,
    input  logic       I_CTS_N,
    output logic [7:0] O_MODE,
    output logic [7:0] O_SYNC1,
    output logic [7:0] O_SYNC2,
    output logic [7:0] O_CMD,
    output logic [1:0] O_BAUD_SEL,
    output logic [3:0] O_CHAR_BITS,
    output logic       O_PAR_EN,
    output logic       O_PAR_EVEN,
    output logic [1:0] O_STOP_SEL,
    output logic       O_TXEN,
    output logic       O_RXE,
    output logic       O_DTR,
    output logic       O_RTS,
    output logic       O_SBRK,
    output logic       O_EH,
    output logic       O_IR_PULSE,
    output logic       O_TXRDY,
    output logic [7:0] O_STATUS,
    output logic [1:0] O_STATE
);
    typedef enum logic [1:0] {ST_MODE, ST_SYNC1, ST_SYNC2, ST_CMD} state_t;
    state_t state, state_nx;
    logic [WE_SYNC_STAGES-1:0] we_sync, we_vld;
    logic [7:0] data_q, mode, sync1, sync2, cmd;
    logic we_edge, armed, commit, cmd_commit, ir_cmd, er_clr, ir_pulse, pe, oe, fe;

    // Strobe synchroniser; armed only once a genuine low has been sampled, so a strobe held through reset never commits
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            we_sync <= '0;
            we_vld  <= '0;
            we_edge <= 1'b0;
            armed   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            we_sync[0] <= I_PORT21_WE;
            we_vld[0]  <= 1'b1;
            for (int i = 1; i < WE_SYNC_STAGES; i++) begin
                we_sync[i] <= we_sync[i-1];
                we_vld[i]  <= we_vld[i-1];
            end
            we_edge <= we_sync[WE_SYNC_STAGES-1];
            armed   <= armed | (we_vld[WE_SYNC_STAGES-1] & ~we_sync[WE_SYNC_STAGES-1]);
            data_q  <= I_DATA;
        end
    end

    assign commit     = armed & we_sync[WE_SYNC_STAGES-1] & ~we_edge;
    assign cmd_commit = commit & (state == ST_CMD);
    assign ir_cmd     = cmd_commit & data_q[6];
    assign er_clr     = cmd_commit & (data_q[4] | data_q[6]);

    // Sequencer state register
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) state <= ST_MODE;
        else       state <= state_nx;
    end

    // Next-state: mode word, optional sync characters, then commands until an internal reset
    always_comb begin
        state_nx = state;
        if (commit)
            case (state)
                ST_MODE:  state_nx = (SYNC_SUPPORT && data_q[1:0] == 2'b00) ? ST_SYNC1 : ST_CMD;
                ST_SYNC1: state_nx = mode[7] ? ST_CMD : ST_SYNC2;
                ST_SYNC2: state_nx = ST_CMD;
                default:  state_nx = data_q[6] ? ST_MODE : ST_CMD;
            endcase
    end

    // Register loads and sticky error flags; a set pulse beats a same-edge clear
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            mode     <= MODE_RESET;
            sync1    <= 8'h00;
            sync2    <= 8'h00;
            cmd      <= 8'h00;
            pe       <= 1'b0;
            oe       <= 1'b0;
            fe       <= 1'b0;
            ir_pulse <= 1'b0;
        end else begin
            if (commit && state == ST_MODE)  mode  <= data_q;
            if (commit && state == ST_SYNC1) sync1 <= data_q;
            if (commit && state == ST_SYNC2) sync2 <= data_q;
            if (ir_cmd)          cmd <= 8'h00;
            else if (cmd_commit) cmd <= data_q & 8'hAF;
            pe       <= I_PE_SET | (pe & ~er_clr);
            oe       <= I_OE_SET | (oe & ~er_clr);
            fe       <= I_FE_SET | (fe & ~er_clr);
            ir_pulse <= ir_cmd;
        end
    end

    assign O_MODE      = mode;
    assign O_SYNC1     = sync1;
    assign O_SYNC2     = sync2;
    assign O_CMD       = cmd;
    assign O_BAUD_SEL  = mode[1:0];
    assign O_CHAR_BITS = 4'd5 + {2'b00, mode[3:2]};
    assign O_PAR_EN    = mode[4];
    assign O_PAR_EVEN  = mode[5];
    assign O_STOP_SEL  = mode[7:6];
    assign O_TXEN      = cmd[0];
    assign O_DTR       = cmd[1];
    assign O_RXE       = cmd[2];
    assign O_SBRK      = cmd[3];
    assign O_RTS       = cmd[5];
    assign O_EH        = cmd[7];
    assign O_IR_PULSE  = ir_pulse;
    assign O_TXRDY     = I_TX_BUF_EMPTY & cmd[0] & ~I_CTS_N;
    assign O_STATUS    = {~I_DSR_N, I_SYNDET, fe, oe, pe, I_TX_EMPTY, I_RX_RDY, I_TX_BUF_EMPTY};
    assign O_STATE     = state;
endmodule

// File: tb/tb_usart_8251_ctrl.sv
// tb_usart_8251_ctrl: scoreboard bench for the 8251 control/status block
module tb_usart_8251_ctrl;
    logic I_CLK = 1'b0, I_RST = 1'b1, I_PORT21_WE = 1'b0;
    logic [7:0] I_DATA = 8'h00;
    logic I_TX_BUF_EMPTY = 1'b1, I_TX_EMPTY = 1'b1, I_RX_RDY = 1'b0;
    logic I_PE_SET = 1'b0, I_OE_SET = 1'b0, I_FE_SET = 1'b0;
    logic I_SYNDET = 1'b0, I_DSR_N = 1'b1, I_CTS_N = 1'b0;
    logic [7:0] O_MODE, O_SYNC1, O_SYNC2, O_CMD, O_STATUS;
    logic [1:0] O_BAUD_SEL, O_STOP_SEL, O_STATE;
    logic [3:0] O_CHAR_BITS;
    logic O_PAR_EN, O_PAR_EVEN, O_TXEN, O_RXE, O_DTR, O_RTS, O_SBRK, O_EH, O_IR_PULSE, O_TXRDY;

    usart_8251_ctrl dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_PORT21_WE(I_PORT21_WE), .I_DATA(I_DATA),
        .I_TX_BUF_EMPTY(I_TX_BUF_EMPTY), .I_TX_EMPTY(I_TX_EMPTY), .I_RX_RDY(I_RX_RDY),
        .I_PE_SET(I_PE_SET), .I_OE_SET(I_OE_SET), .I_FE_SET(I_FE_SET),
        .I_SYNDET(I_SYNDET), .I_DSR_N(I_DSR_N), .I_CTS_N(I_CTS_N),
        .O_MODE(O_MODE), .O_SYNC1(O_SYNC1), .O_SYNC2(O_SYNC2), .O_CMD(O_CMD),
        .O_BAUD_SEL(O_BAUD_SEL), .O_CHAR_BITS(O_CHAR_BITS), .O_PAR_EN(O_PAR_EN),
        .O_PAR_EVEN(O_PAR_EVEN), .O_STOP_SEL(O_STOP_SEL), .O_TXEN(O_TXEN), .O_RXE(O_RXE),
        .O_DTR(O_DTR), .O_RTS(O_RTS), .O_SBRK(O_SBRK), .O_EH(O_EH), .O_IR_PULSE(O_IR_PULSE),
        .O_TXRDY(O_TXRDY), .O_STATUS(O_STATUS), .O_STATE(O_STATE)
    );

    always #5 I_CLK = ~I_CLK;

    int pass_cnt = 0, total = 0, ir_cnt = 0, lat = 0;
    logic mon_en = 1'b0;
    logic [34:0] q[$];
    logic [34:0] cur, prev, e;

    // Monitor: every visible register/state change must match the next expected commit
    always @(negedge I_CLK) begin
        cur = {O_STATE, O_MODE, O_SYNC1, O_SYNC2, O_CMD, O_IR_PULSE};
        if (mon_en && cur[34:1] !== prev[34:1]) begin
            total++;
            if (q.size() == 0) $display("FAIL unexpected_commit got=%h", cur);
            else begin
                e = q.pop_front();
                if (cur === e) pass_cnt++;
                else $display("FAIL commit got=%h exp=%h", cur, e);
            end
        end
        if (mon_en && O_IR_PULSE) ir_cnt++;
        prev = cur;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    endtask

    task automatic expect_commit(input logic [1:0] st, input logic [7:0] m, s1, s2, c, input logic ir);
        q.push_back({st, m, s1, s2, c, ir});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            @(posedge I_CLK);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            $display("FAIL commit_timeout pending=%0d", q.size());
            q.delete();
        end
        repeat (2) @(negedge I_CLK);
    endtask

    task automatic wr(input logic [7:0] d, input logic [1:0] st, input logic [7:0] m, s1, s2, c, input logic ir);
        expect_commit(st, m, s1, s2, c, ir);
        @(negedge I_CLK);
        I_DATA = d;
        I_PORT21_WE = 1'b1;
        repeat (3) @(negedge I_CLK);
        I_PORT21_WE = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge I_CLK);
        chk("rst_state", O_STATE, 0);
        chk("rst_mode", O_MODE, 8'h00);
        chk("rst_cmd", O_CMD, 8'h00);
        chk("rst_sync1", O_SYNC1, 8'h00);
        chk("rst_status", O_STATUS, 8'h05);
        chk("rst_txrdy", O_TXRDY, 0);
        I_RST = 1'b0;
        @(negedge I_CLK);
        #1 mon_en = 1'b1;
        repeat (2) @(negedge I_CLK);
        wr(8'h4E, 2'd3, 8'h4E, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("char_bits", O_CHAR_BITS, 8);
        chk("baud_sel", O_BAUD_SEL, 2);
        chk("stop_sel", O_STOP_SEL, 1);
        chk("par_en", O_PAR_EN, 0);
        wr(8'h37, 2'd3, 8'h4E, 8'h00, 8'h00, 8'h27, 1'b0);
        chk("cmd_bits", {O_TXEN, O_RXE, O_DTR, O_RTS, O_SBRK, O_EH}, 6'b111100);
        chk("txrdy_cts_on", O_TXRDY, 1);
        I_CTS_N = 1'b1;
        #1 chk("txrdy_cts_off", O_TXRDY, 0);
        I_CTS_N = 1'b0;
        wr(8'h40, 2'd0, 8'h4E, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("ir_count1", ir_cnt, 1);
        wr(8'h0C, 2'd1, 8'h0C, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("baud_sync", O_BAUD_SEL, 0);
        wr(8'h16, 2'd2, 8'h0C, 8'h16, 8'h00, 8'h00, 1'b0);
        wr(8'h16, 2'd3, 8'h0C, 8'h16, 8'h16, 8'h00, 1'b0);
        wr(8'h05, 2'd3, 8'h0C, 8'h16, 8'h16, 8'h05, 1'b0);
        wr(8'h01, 2'd3, 8'h0C, 8'h16, 8'h16, 8'h01, 1'b0);
        chk("txrdy_cmd01", O_TXRDY, 1);
        I_CTS_N = 1'b1;
        #1 chk("txrdy_cmd01_cts", O_TXRDY, 0);
        I_CTS_N = 1'b0;
        wr(8'h00, 2'd3, 8'h0C, 8'h16, 8'h16, 8'h00, 1'b0);
        chk("txrdy_cmd00", O_TXRDY, 0);
        chk("status_txbe", O_STATUS[0], 1);
        @(negedge I_CLK) I_OE_SET = 1'b1;
        @(negedge I_CLK) I_OE_SET = 1'b0;
        chk("oe_set", O_STATUS[4], 1);
        wr(8'h15, 2'd3, 8'h0C, 8'h16, 8'h16, 8'h05, 1'b0);
        chk("oe_cleared", O_STATUS[4], 0);
        expect_commit(2'd3, 8'h0C, 8'h16, 8'h16, 8'h04, 1'b0);
        @(negedge I_CLK);
        I_DATA = 8'h14;
        I_PORT21_WE = 1'b1;
        repeat (2) @(posedge I_CLK);
        #1 I_PE_SET = 1'b1;
        @(posedge I_CLK);
        #1 I_PE_SET = 1'b0;
        @(negedge I_CLK) I_PORT21_WE = 1'b0;
        drain();
        chk("pe_set_wins", O_STATUS[3], 1);
        @(negedge I_CLK) I_FE_SET = 1'b1;
        @(negedge I_CLK) I_FE_SET = 1'b0;
        chk("fe_set", O_STATUS[5], 1);
        wr(8'h40, 2'd0, 8'h0C, 8'h16, 8'h16, 8'h00, 1'b1);
        chk("ir_clears_err", O_STATUS[5:3], 0);
        chk("ir_count2", ir_cnt, 2);
        expect_commit(2'd1, 8'h8C, 8'h16, 8'h16, 8'h00, 1'b0);
        @(negedge I_CLK);
        I_DATA = 8'h8C;
        I_PORT21_WE = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge I_CLK);
            #1 if (lat == 0 && O_STATE == 2'd1) lat = k;
        end
        @(negedge I_CLK) I_PORT21_WE = 1'b0;
        drain();
        chk("commit_latency", lat, 3);
        @(negedge I_CLK);
        mon_en = 1'b0;
        I_RST = 1'b1;
        #1;
        chk("rst2_state", O_STATE, 0);
        chk("rst2_regs", {O_MODE, O_SYNC1, O_SYNC2, O_CMD}, 32'h0);
        chk("rst2_flags", {O_STATUS[5:3], O_IR_PULSE}, 0);
        I_DATA = 8'h4E;
        I_PORT21_WE = 1'b1;
        repeat (2) @(negedge I_CLK);
        I_RST = 1'b0;
        #1 mon_en = 1'b1;
        repeat (10) @(negedge I_CLK);
        chk("held_we_no_commit", {O_STATE, O_MODE}, 0);
        I_PORT21_WE = 1'b0;
        repeat (3) @(negedge I_CLK);
        wr(8'h4E, 2'd3, 8'h4E, 8'h00, 8'h00, 8'h00, 1'b0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
